// File: rtl/mod241_serial_reduce.sv
// Serial MSB-first mod-241 reducer: folds 6-bit chunks via r = (64*r + chunk) mod 241.
// Optional length check enabled by defining MOD241_LEN_CHECK_EN.
module mod241_serial_reduce #(
  parameter int NCHUNK = 67
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] in_chunk,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_res,
  output logic       len_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_r;
  state_t     state_next_s;
  logic [7:0] acc_r;
  logic       accept_s;
  logic       release_s;

  // One Horner step; two folds of 256 == 15 (mod 241) then one conditional subtract.
  function automatic logic [7:0] mod241_step(input logic [7:0] acc, input logic [5:0] chunk);
    logic [13:0] t;
    logic [10:0] u;
    logic [8:0]  v;
    t = {acc, 6'd0} + {8'd0, chunk};
    u = ({5'd0, t[13:8]} * 11'd15) + {3'd0, t[7:0]};
    v = ({6'd0, u[10:8]} * 9'd15) + {1'b0, u[7:0]};
    return (v >= 9'd241) ? 8'(v - 9'd241) : v[7:0];
  endfunction

  assign accept_s  = in_valid & in_ready;
  assign release_s = (state_r == DONE) & out_ready;

  // State and accumulator registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      acc_r   <= 8'd0;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        acc_r <= mod241_step(acc_r, in_chunk);
      end else if (release_s) begin
        acc_r <= 8'd0;
      end else begin
        acc_r <= acc_r;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE, ACC: begin
        if (accept_s) begin
          state_next_s = in_last ? DONE : ACC;
        end else begin
          state_next_s = state_r;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode; in_ready is held low while reset is asserted
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_res   = acc_r;
    case (state_r)
      IDLE, ACC: begin
        in_ready  = ~rst;
        out_valid = 1'b0;
      end
      DONE: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

`ifdef MOD241_LEN_CHECK_EN
  logic [6:0] cnt_r;
  logic [7:0] cnt_inc_s;
  logic       len_err_r;

  assign cnt_inc_s = {1'b0, cnt_r} + 8'd1;

  // Chunk counter (saturating so overlong operands cannot alias to a legal length) and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= 7'd0;
      len_err_r <= 1'b0;
    end else if (accept_s) begin
      if (in_last) begin
        cnt_r     <= 7'd0;
        len_err_r <= (cnt_inc_s != 8'(NCHUNK));
      end else begin
        cnt_r     <= (cnt_r == 7'd127) ? cnt_r : cnt_r + 7'd1;
        len_err_r <= len_err_r;
      end
    end else if (release_s) begin
      cnt_r     <= 7'd0;
      len_err_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_r;
      len_err_r <= len_err_r;
    end
  end

  assign len_err = len_err_r;
`else
  logic unused_nchunk_s;
  assign unused_nchunk_s = ^NCHUNK;
  assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_mod241_serial_reduce.sv
// Self-checking bench for mod241_serial_reduce: directed cases plus randomized operands
// checked against a plain-arithmetic Horner model.
module tb_mod241_serial_reduce;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_chunk;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_res;
  logic       len_err;

  int checks   = 0;
  int failures = 0;
  logic [5:0] chunk_a [0:66];

  mod241_serial_reduce dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_chunk  (in_chunk),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_res(input int n);
    int r = 0;
    for (int i = 0; i < n; i++) r = (r * 64 + int'(chunk_a[i])) % 241;
    return r;
  endfunction

  function automatic logic model_len_err(input int n);
`ifdef MOD241_LEN_CHECK_EN
    return (n != 67);
`else
    return 1'b0;
`endif
  endfunction

  task automatic clear_chunks();
    for (int i = 0; i < 67; i++) chunk_a[i] = 6'd0;
  endtask

  // Called at a negedge; returns at the negedge after the output handshake.
  task automatic run_op(input int n, input int stall, input bit gaps, input int exp_res);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_chunk = 6'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_chunk = chunk_a[i];
      in_last  = (i == n - 1);
      #1;
      check_eq("in_ready_acc", in_ready, 1'b1);
      if (i == n - 1) check_eq("valid_before_last", out_valid, 1'b0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
    check_eq("out_valid", out_valid, 1'b1);
    check_eq("out_res", out_res, exp_res);
    check_eq("len_err", len_err, model_len_err(n));
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      in_chunk = 6'($urandom);
      @(negedge clk);
      #1;
      check_eq("stall_valid", out_valid, 1'b1);
      check_eq("stall_res", out_res, exp_res);
      check_eq("stall_in_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check_eq("post_hs_valid", out_valid, 1'b0);
    check_eq("post_hs_in_ready", in_ready, 1'b1);
    check_eq("post_hs_len_err", len_err, 1'b0);
  endtask

  initial begin
    int n;
    int k;
    int val;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_chunk  = 6'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #1;
    check_eq("rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("reset_in_ready", in_ready, 1'b1);
    check_eq("reset_out_valid", out_valid, 1'b0);
    check_eq("reset_out_res", out_res, 8'd0);
    check_eq("reset_len_err", len_err, 1'b0);

    clear_chunks();
    run_op(67, 0, 1'b0, 0);

    clear_chunks();
    chunk_a[65] = 6'd3;  chunk_a[66] = 6'd49;
    run_op(67, 1, 1'b1, 0);

    clear_chunks();
    chunk_a[65] = 6'd15; chunk_a[66] = 6'd40;
    run_op(67, 0, 1'b0, 36);

    for (int i = 0; i < 67; i++) chunk_a[i] = 6'h3F;
    chunk_a[0] = 6'h0F;
    run_op(67, 2, 1'b1, 224);

    clear_chunks();
    chunk_a[65] = 6'd3;  chunk_a[66] = 6'd48;
    run_op(67, 5, 1'b0, 240);

    // Next operand must start from a cleared accumulator
    for (int i = 0; i < 5; i++) chunk_a[i] = 6'($urandom);
    run_op(5, 0, 1'b0, model_res(5));

    // Single-chunk operand
    chunk_a[0] = 6'd63;
    run_op(1, 1, 1'b0, 63);

    // Short operand: in_last on the 10th chunk
    for (int i = 0; i < 10; i++) chunk_a[i] = 6'($urandom);
    run_op(10, 2, 1'b0, model_res(10));

    // Abort after 30 chunks with a reset pulse
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1;
      in_chunk = 6'($urandom);
      in_last  = 1'b0;
      @(negedge clk);
    end
    rst      = 1'b1;
    in_chunk = 6'd5;
    in_last  = 1'b1;
    #1;
    check_eq("midrst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
    check_eq("midrst_out_valid", out_valid, 1'b0);
    check_eq("midrst_out_res", out_res, 8'd0);
    check_eq("midrst_len_err", len_err, 1'b0);
    @(negedge clk);
    #1;
    check_eq("midrst_no_output", out_valid, 1'b0);
    clear_chunks();
    k   = $urandom_range(0, 1000);
    val = 241 * k + 17;
    chunk_a[64] = 6'((val >> 12) & 63);
    chunk_a[65] = 6'((val >> 6) & 63);
    chunk_a[66] = 6'(val & 63);
    run_op(67, 1, 1'b1, 17);

    // Randomized operands against the model
    for (int t = 0; t < 12; t++) begin
      n = ($urandom_range(0, 2) == 0) ? 67 : $urandom_range(1, 67);
      for (int i = 0; i < n; i++) chunk_a[i] = 6'($urandom);
      run_op(n, $urandom_range(0, 3), 1'b1, model_res(n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
